// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMadd  = 3'd4,
    OpMaddu = 3'd5,
    OpMsub  = 3'd6,
    OpMsubu = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } md_state_t;

  function automatic logic md_is_div(md_op_t op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  // Every even op code is the signed variant.
  function automatic logic md_is_signed(md_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring divider datapath: one quotient bit per step, sign fix-up and divide-by-zero result.
module muldiv_div_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q, dividend_q;
  logic            neg_quo_q, neg_rem_q, zero_q;
  logic            a_neg, b_neg;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] rem_n, quo_n;

  assign a_neg = is_signed & dividend[XLEN-1];
  assign b_neg = is_signed & divisor[XLEN-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dividend_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
    end else if (load) begin
      rem_q      <= '0;
      quo_q      <= a_neg ? -dividend : dividend;
      dvs_q      <= b_neg ? -divisor : divisor;
      dividend_q <= dividend;
      neg_quo_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      zero_q     <= (divisor == '0);
    end else if (step) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
    end
  end

  // Result reflects the step taken at the coming edge, so the last step commits directly.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_n = diff[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = shifted[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
    if (zero_q) begin
      quotient  = '1;
      remainder = dividend_q;
    end else begin
      quotient  = neg_quo_q ? -quo_n : quo_n;
      remainder = neg_rem_q ? -rem_n : rem_n;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers, MADD/MSUB accumulation, iterative divide and cancel.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            cancel,
  input  logic            wr_en,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wr_data,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned MaxLat = (MUL_LAT > XLEN) ? MUL_LAT : XLEN;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);

  md_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  md_op_t            op_q;
  logic [2*XLEN-1:0] prod_q, prod_d, a_ext, b_ext, acc, mul_res;
  logic [XLEN-1:0]   hi_q, lo_q, div_quo, div_rem;
  logic              accept, last, div_load, div_step, mul_commit, div_commit;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (accept) state_d = md_is_div(op) ? StDiv : StMul;
      StMul, StDiv: if (cancel || last) state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    accept     = (state_q == StIdle) && start && !cancel;
    last       = ((state_q == StMul) && (cnt_q == MulLast)) ||
                 ((state_q == StDiv) && (cnt_q == DivLast));
    div_load   = accept && md_is_div(op);
    div_step   = (state_q == StDiv);
    // Cancel in the final cycle still wins over the commit.
    mul_commit = (state_q == StMul) && last && !cancel;
    div_commit = (state_q == StDiv) && last && !cancel;
  end

  always_comb begin
    a_ext  = {{XLEN{md_is_signed(op) & src_a[XLEN-1]}}, src_a};
    b_ext  = {{XLEN{md_is_signed(op) & src_b[XLEN-1]}}, src_b};
    prod_d = a_ext * b_ext;
    acc    = {hi_q, lo_q};
    case (op_q)
      OpMadd, OpMaddu: mul_res = acc + prod_q;
      OpMsub, OpMsubu: mul_res = acc - prod_q;
      default:         mul_res = prod_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      op_q   <= OpMult;
      prod_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q <= (busy && !cancel && !last) ? cnt_q + 1'b1 : '0;
      if (accept) begin
        op_q   <= op;
        prod_q <= prod_d;
      end
      if (mul_commit) begin
        {hi_q, lo_q} <= mul_res;
      end else if (div_commit) begin
        hi_q <= div_rem;
        lo_q <= div_quo;
      end else if ((state_q == StIdle) && wr_en) begin
        if (wr_hi) hi_q <= wr_data;
        else       lo_q <= wr_data;
      end
    end
  end

  muldiv_div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .step     (div_step),
    .is_signed(md_is_signed(op)),
    .dividend (src_a),
    .divisor  (src_b),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
